// File: rtl/er_final_adder_pkg.sv
// Shared widths, bit positions and FSM encoding for the error-recovery final adder.
// Bit numbering follows the multiplier layers: e1/p bit 1 carries weight 2^0.
package er_final_adder_pkg;

    localparam int ER_W   = 32;
    localparam int EP_LSB = 9;
    localparam int EP_MSB = 24;
    localparam int E1_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } er_state_t;

    // Number of clocks needed to sweep the full product width chunk by chunk.
    function automatic int er_nch(input int chunk);
        return (ER_W + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/er_chunk_add.sv
// Purpose: one W-bit slice of the final ripple, a + b + cin -> sum, cout.
// Latency: combinational.
// Backpressure: none, pure datapath.
module er_chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/er_final_adder.sv
// Purpose: adds Layer4's e1 and (optionally) the ep recovery vector into p, CHUNK bits per clock.
// Latency: NCH clocks in ADD after the accept edge, result then held in DONE.
// Backpressure: in_ready only in IDLE; out_valid/p held stable until out_ready.
module er_final_adder
    import er_final_adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [E1_MSB:1]      e1,
    input  logic [EP_MSB:EP_LSB] ep,
    input  logic                 rec_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ER_W:1]        p,
    output logic                 busy
);

    localparam int NCH = er_nch(CHUNK);
    // Operands are padded to a whole number of chunks so the last partial slice needs no special case.
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = $clog2(NCH) + 1;

    er_state_t       state_q, state_d;
    logic [PW-1:0]   a_q, b_q, p_q, p_nxt;
    logic [PW-1:0]   a_op, b_op;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic [CHUNK-1:0] slice_sum;
    logic            slice_cout;

    assign a_op = PW'({1'b0, e1});
    assign b_op = rec_en ? PW'({{(ER_W - EP_MSB){1'b0}}, ep, {(EP_LSB - 1){1'b0}}}) : '0;

    // a_q/b_q shift right each ADD cycle, so the active slice always sits at bit 0.
    er_chunk_add #(.W(CHUNK)) u_chunk_add (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        p_nxt = p_q;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i)) begin
                p_nxt[i*CHUNK +: CHUNK] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_ADD;
            end
            ST_ADD: begin
                busy = 1'b1;
                if (cnt_q == CW'(NCH - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                a_q     <= a_op;
                b_q     <= b_op;
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == ST_ADD) begin
                a_q     <= a_q >> CHUNK;
                b_q     <= b_q >> CHUNK;
                p_q     <= p_nxt;
                carry_q <= slice_cout;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign p = p_q[ER_W-1:0];

endmodule

// File: tb/tb_er_final_adder.sv
// Scoreboard bench for er_final_adder: expected p pushed on drive, popped on each output handshake.
module tb_er_final_adder;

    localparam int CHUNK = 8;
    localparam int NCH   = (32 + CHUNK - 1) / CHUNK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:1] e1 = '0;
    logic [24:9] ep = '0;
    logic        rec_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [32:1] p;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] sb[$];

    er_final_adder #(.CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e1        (e1),
        .ep        (ep),
        .rec_en    (rec_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [30:0] a, input logic [15:0] r, input logic en);
        logic [31:0] b;
        b = en ? {8'h00, r, 8'h00} : 32'h0;
        return {1'b0, a} + b;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                chk("p", p, exp);
            end
        end
    end

    task automatic send(input logic [30:0] a, input logic [15:0] r, input logic en,
                        input logic [31:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        e1 = a; ep = r; rec_en = en; in_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts clocks with the accept edge as clock 1.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [30:0] ra;
        logic [15:0] rr;
        logic        re;

        #3;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_p", p, 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        send(31'h7FFFFFFF, 16'hFFFF, 1'b1, 32'h80FFFEFF);
        chk("add_busy", {31'b0, busy}, 32'd1);
        chk("add_in_ready", {31'b0, in_ready}, 32'd0);
        wait_out(n);
        chk("latency", n, NCH + 1);
        @(posedge clk); #1;

        send(31'h7FFFFFFF, 16'hFFFF, 1'b0, 32'h7FFFFFFF);
        wait_out(n);
        chk("latency_norec", n, NCH + 1);
        @(posedge clk); #1;

        send(31'h00FFFFFF, 16'h0001, 1'b1, 32'h010000FF);
        wait_out(n);
        @(posedge clk); #1;

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        send(31'h12345678, 16'hABCD, 1'b1, 32'h12E02378);
        wait_out(n);
        chk("bp_latency", n, NCH + 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; e1 = 31'($urandom); ep = 16'($urandom); rec_en = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_p", p, 32'h12E02378);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // Reset mid-ADD aborts; the discarded op is never pushed.
        e1 = 31'h55555555; ep = 16'h1234; rec_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_p", p, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", {31'b0, out_valid}, 32'd0);
        end
        send(31'h1, 16'h0, 1'b1, 32'h1);
        wait_out(n);
        @(posedge clk); #1;

        for (int i = 0; i < 2000; i++) begin
            ra = 31'($urandom);
            rr = 16'($urandom);
            re = 1'($urandom_range(0, 1));
            if (i % 7 == 0) ra = 31'h7FFFFFFF;
            send(ra, rr, re, model(ra, rr, re));
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
